// File: rtl/reg_file_2r1w.sv
// Register file: one write port, two read ports, byte strobes, write-first bypass.
// Latency: reads return one cycle after RdEnX; writes land at the next edge.
// Backpressure: none; every request completes, out-of-range accesses pulse AddrErr.
// Optional feature macro: REGFILE_PARITY_EN (one even-parity bit per entry).
module reg_file_2r1w #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_EXPORT = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        WrEn,
  input  logic [ADDR_WIDTH-1:0]       WrAddr,
  input  logic [WIDTH-1:0]            WrData,
  input  logic [WIDTH/8-1:0]          WrStrb,
  input  logic                        RdEnA,
  input  logic [ADDR_WIDTH-1:0]       RdAddrA,
  input  logic                        RdEnB,
  input  logic [ADDR_WIDTH-1:0]       RdAddrB,
  output logic [WIDTH-1:0]            RdDataA,
  output logic [WIDTH-1:0]            RdDataB,
  output logic                        RdValidA,
  output logic                        RdValidB,
  output logic                        AddrErr,
  output logic                        ParErrA,
  output logic                        ParErrB,
  input  logic                        InjParErr,
  output logic [NUM_EXPORT*WIDTH-1:0] REG_EXPORT
);

  localparam int NB = WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_wr_ok, w_wr_bad;
  logic             w_rda_ok, w_rda_bad, w_rdb_ok, w_rdb_bad;
  logic             w_rda_hit, w_rdb_hit;
  logic [WIDTH-1:0] w_wr_old, w_rda_old, w_rdb_old;
  logic [WIDTH-1:0] w_wr_merged;
  logic [WIDTH-1:0] w_rda_data, w_rdb_data;

  assign w_wr_ok   = WrEn  && ({1'b0, WrAddr}  < LP_DEPTH);
  assign w_wr_bad  = WrEn  && !({1'b0, WrAddr}  < LP_DEPTH);
  assign w_rda_ok  = RdEnA && ({1'b0, RdAddrA} < LP_DEPTH);
  assign w_rda_bad = RdEnA && !({1'b0, RdAddrA} < LP_DEPTH);
  assign w_rdb_ok  = RdEnB && ({1'b0, RdAddrB} < LP_DEPTH);
  assign w_rdb_bad = RdEnB && !({1'b0, RdAddrB} < LP_DEPTH);

  // Address-decoded lookups; out-of-range addresses simply match no entry.
  always_comb begin
    w_wr_old  = '0;
    w_rda_old = '0;
    w_rdb_old = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WrAddr  == ADDR_WIDTH'(i)) w_wr_old  = r_mem[i];
      if (RdAddrA == ADDR_WIDTH'(i)) w_rda_old = r_mem[i];
      if (RdAddrB == ADDR_WIDTH'(i)) w_rdb_old = r_mem[i];
    end
  end

  // Byte-strobe merge of new write data over the current entry contents.
  always_comb begin
    w_wr_merged = '0;
    for (int b = 0; b < NB; b++) begin
      w_wr_merged[b*8 +: 8] = WrStrb[b] ? WrData[b*8 +: 8] : w_wr_old[b*8 +: 8];
    end
  end

  // Write-first: a read of the address being written sees the merged word.
  assign w_rda_hit  = w_wr_ok && (RdAddrA == WrAddr);
  assign w_rdb_hit  = w_wr_ok && (RdAddrB == WrAddr);
  assign w_rda_data = !w_rda_ok ? '0 : (w_rda_hit ? w_wr_merged : w_rda_old);
  assign w_rdb_data = !w_rdb_ok ? '0 : (w_rdb_hit ? w_wr_merged : w_rdb_old);

  // Storage update; reset wins over any write in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WrAddr == ADDR_WIDTH'(i)) r_mem[i] <= w_wr_merged;
      end
    end
  end

  // Registered read ports; data holds while idle, valid follows the request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RdDataA  <= '0;
      RdDataB  <= '0;
      RdValidA <= 1'b0;
      RdValidB <= 1'b0;
    end else begin
      RdValidA <= RdEnA;
      RdValidB <= RdEnB;
      if (RdEnA) RdDataA <= w_rda_data;
      if (RdEnB) RdDataB <= w_rdb_data;
    end
  end

  // One shared error pulse, however many accesses were out of range.
  always_ff @(posedge CLK) begin
    if (RST) AddrErr <= 1'b0;
    else     AddrErr <= w_wr_bad || w_rda_bad || w_rdb_bad;
  end

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             w_wr_par;
  logic             w_rda_par_old, w_rdb_par_old;
  logic             w_rda_par, w_rdb_par;

  // Even parity over the full merged word; injection flips the stored bit.
  assign w_wr_par = (^w_wr_merged) ^ InjParErr;

  // Stored-parity lookup for each read port.
  always_comb begin
    w_rda_par_old = 1'b0;
    w_rdb_par_old = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddrA == ADDR_WIDTH'(i)) w_rda_par_old = r_par[i];
      if (RdAddrB == ADDR_WIDTH'(i)) w_rdb_par_old = r_par[i];
    end
  end

  assign w_rda_par = w_rda_hit ? w_wr_par : w_rda_par_old;
  assign w_rdb_par = w_rdb_hit ? w_wr_par : w_rdb_par_old;

  // Parity storage tracks the data storage write-for-write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WrAddr == ADDR_WIDTH'(i)) r_par[i] <= w_wr_par;
      end
    end
  end

  // Parity check result, only meaningful alongside RdValidX.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ParErrA <= 1'b0;
      ParErrB <= 1'b0;
    end else begin
      ParErrA <= w_rda_ok && (w_rda_par ^ (^w_rda_data));
      ParErrB <= w_rdb_ok && (w_rdb_par ^ (^w_rdb_data));
    end
  end
`else
  logic w_unused_inj;
  assign w_unused_inj = InjParErr;
  assign ParErrA      = 1'b0;
  assign ParErrB      = 1'b0;
`endif

  // Export the low entries straight from storage (no bypass).
  for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
    assign REG_EXPORT[g*WIDTH +: WIDTH] = r_mem[g];
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;
  localparam int WIDTH = 16;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NEXP  = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             WrEn;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic [1:0]       WrStrb;
  logic             RdEnA, RdEnB;
  logic [AW-1:0]    RdAddrA, RdAddrB;
  logic [WIDTH-1:0] RdDataA, RdDataB;
  logic             RdValidA, RdValidB;
  logic             AddrErr, ParErrA, ParErrB;
  logic             InjParErr;
  logic [NEXP*WIDTH-1:0] REG_EXPORT;

  int errors = 0;
  int checks = 0;

  reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_EXPORT(NEXP)) dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrStrb(WrStrb),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
    .RdDataA(RdDataA), .RdDataB(RdDataB), .RdValidA(RdValidA), .RdValidB(RdValidB),
    .AddrErr(AddrErr), .ParErrA(ParErrA), .ParErrB(ParErrB), .InjParErr(InjParErr),
    .REG_EXPORT(REG_EXPORT)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0; WrStrb = '0;
    RdEnA = 1'b0; RdAddrA = '0; RdEnB = 1'b0; RdAddrB = '0; InjParErr = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [1:0] s);
    WrEn = 1'b1; WrAddr = a; WrData = d; WrStrb = s;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    step();
    checks++; if (RdDataA !== 16'h0) begin errors++; $display("FAIL reset_rddataa got=%h exp=0000", RdDataA); end
    checks++; if (RdDataB !== 16'h0) begin errors++; $display("FAIL reset_rddatab got=%h exp=0000", RdDataB); end
    checks++; if ({RdValidA, RdValidB, AddrErr, ParErrA, ParErrB} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got=%b exp=00000", {RdValidA, RdValidB, AddrErr, ParErrA, ParErrB}); end
    checks++; if (REG_EXPORT !== 64'h0) begin errors++; $display("FAIL reset_export got=%h exp=0", REG_EXPORT); end
    idle();
  endtask

  task automatic test_strobe();
    wr(4'd3, 16'hABCD, 2'b11); step();
    wr(4'd3, 16'h1200, 2'b10); step();
    idle();
    checks++; if (REG_EXPORT[63:48] !== 16'h12CD) begin errors++; $display("FAIL strobe_export got=%h exp=12cd", REG_EXPORT[63:48]); end
    RdEnA = 1'b1; RdAddrA = 4'd3; step();
    checks++; if (RdDataA !== 16'h12CD || RdValidA !== 1'b1) begin errors++;
      $display("FAIL strobe_read got=%h/%b exp=12cd/1", RdDataA, RdValidA); end
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("FAIL strobe_addrerr got=%b exp=0", AddrErr); end
    idle();
    wr(4'd3, 16'h77EE, 2'b01); step();
    checks++; if (REG_EXPORT[63:48] !== 16'h12EE) begin errors++; $display("FAIL strobe_low got=%h exp=12ee", REG_EXPORT[63:48]); end
    wr(4'd3, 16'hFFFF, 2'b00); step();
    idle(); step();
    checks++; if (REG_EXPORT[63:48] !== 16'h12EE || AddrErr !== 1'b0) begin errors++;
      $display("FAIL strobe_zero got=%h/%b exp=12ee/0", REG_EXPORT[63:48], AddrErr); end
  endtask

  task automatic test_collision();
    idle();
    wr(4'd5, 16'h5555, 2'b11);
    RdEnA = 1'b1; RdAddrA = 4'd5; RdEnB = 1'b1; RdAddrB = 4'd5;
    step();
    checks++; if (RdDataA !== 16'h5555 || RdValidA !== 1'b1) begin errors++;
      $display("FAIL collide_a got=%h/%b exp=5555/1", RdDataA, RdValidA); end
    checks++; if (RdDataB !== 16'h5555 || RdValidB !== 1'b1) begin errors++;
      $display("FAIL collide_b got=%h/%b exp=5555/1", RdDataB, RdValidB); end
    idle();
    wr(4'd3, 16'h3400, 2'b10);
    RdEnA = 1'b1; RdAddrA = 4'd3;
    step();
    checks++; if (RdDataA !== 16'h34EE) begin errors++; $display("FAIL collide_merge got=%h exp=34ee", RdDataA); end
    idle();
  endtask

  task automatic test_hold();
    idle(); step();
    checks++; if (RdValidA !== 1'b0 || RdValidB !== 1'b0) begin errors++;
      $display("FAIL hold_valid got=%b%b exp=00", RdValidA, RdValidB); end
    checks++; if (RdDataA !== 16'h34EE || RdDataB !== 16'h5555) begin errors++;
      $display("FAIL hold_data got=%h/%h exp=34ee/5555", RdDataA, RdDataB); end
  endtask

  task automatic test_addr_err();
    idle();
    wr(4'd13, 16'hFFFF, 2'b11);
    RdEnB = 1'b1; RdAddrB = 4'd14;
    RdEnA = 1'b1; RdAddrA = 4'd5;
    step();
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("FAIL oor_pulse got=%b exp=1", AddrErr); end
    checks++; if (RdDataB !== 16'h0 || RdValidB !== 1'b1) begin errors++;
      $display("FAIL oor_readb got=%h/%b exp=0000/1", RdDataB, RdValidB); end
    checks++; if (RdDataA !== 16'h5555 || RdValidA !== 1'b1) begin errors++;
      $display("FAIL oor_reada got=%h/%b exp=5555/1", RdDataA, RdValidA); end
    idle();
    RdEnA = 1'b1; RdAddrA = 4'd11; RdEnB = 1'b1; RdAddrB = 4'd5;
    step();
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("FAIL oor_single got=%b exp=0", AddrErr); end
    checks++; if (RdDataA !== 16'h0 || RdDataB !== 16'h5555) begin errors++;
      $display("FAIL oor_nochange got=%h/%h exp=0000/5555", RdDataA, RdDataB); end
    checks++; if (REG_EXPORT !== 64'h34EE_0000_0000_0000) begin errors++;
      $display("FAIL oor_export got=%h exp=34ee000000000000", REG_EXPORT); end
    idle();
  endtask

  task automatic test_reset_override();
    idle();
    RST = 1'b1;
    wr(4'd1, 16'hBEEF, 2'b11);
    RdEnA = 1'b1; RdAddrA = 4'd3;
    step();
    checks++; if (RdValidA !== 1'b0 || RdDataA !== 16'h0) begin errors++;
      $display("FAIL rstovr_read got=%h/%b exp=0000/0", RdDataA, RdValidA); end
    checks++; if (REG_EXPORT !== 64'h0) begin errors++; $display("FAIL rstovr_export got=%h exp=0", REG_EXPORT); end
    idle();
    RdEnA = 1'b1; RdAddrA = 4'd1; RdEnB = 1'b1; RdAddrB = 4'd5;
    wr(4'd2, 16'h00A5, 2'b11);
    step();
    checks++; if (RdDataA !== 16'h0 || RdDataB !== 16'h0 || RdValidA !== 1'b1) begin errors++;
      $display("FAIL rstovr_after got=%h/%h/%b exp=0000/0000/1", RdDataA, RdDataB, RdValidA); end
    checks++; if (REG_EXPORT[47:32] !== 16'h00A5) begin errors++;
      $display("FAIL rst_release got=%h exp=00a5", REG_EXPORT[47:32]); end
    idle();
  endtask

  task automatic test_parity();
    idle();
    wr(4'd2, 16'h0001, 2'b11); InjParErr = 1'b1; step();
    idle();
    RdEnA = 1'b1; RdAddrA = 4'd2; RdEnB = 1'b1; RdAddrB = 4'd3; step();
    checks++; if (RdDataA !== 16'h0001 || RdValidA !== 1'b1) begin errors++;
      $display("FAIL par_data got=%h/%b exp=0001/1", RdDataA, RdValidA); end
`ifdef REGFILE_PARITY_EN
    checks++; if (ParErrA !== 1'b1) begin errors++; $display("FAIL par_inject got=%b exp=1", ParErrA); end
`else
    checks++; if (ParErrA !== 1'b0) begin errors++; $display("FAIL par_tied got=%b exp=0", ParErrA); end
`endif
    checks++; if (ParErrB !== 1'b0) begin errors++; $display("FAIL par_clean_b got=%b exp=0", ParErrB); end
    idle();
    wr(4'd2, 16'h0001, 2'b11); step();
    idle();
    RdEnA = 1'b1; RdAddrA = 4'd2; step();
    checks++; if (ParErrA !== 1'b0 || RdDataA !== 16'h0001) begin errors++;
      $display("FAIL par_rewrite got=%b/%h exp=0/0001", ParErrA, RdDataA); end
    idle(); step();
  endtask

  initial begin
    idle();
    test_reset();
    test_strobe();
    test_collision();
    test_hold();
    test_addr_err();
    test_reset_override();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
